eth_frame_scheduler: RTL and testbench

Sequences the Ethernet transmit datapath for audio streaming. Collects 16-bit audio samples into a ping-pong buffer of two banks, each holding one frame payload. When a bank is full, it requests a frame from the RMII transmitter, then serves that bank's payload as di-bits on demand. It enforces a minimum idle gap between frames and flags sample loss when both banks are occupied. It sits between the audio sample source and the frame transmitter, in the `eth_clk` domain.

---
 rtl/eth_frame_scheduler_if.sv | 31 +++
 rtl/eth_frame_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_eth_frame_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_scheduler_if.sv
// Handshake bundle between the audio sample source, the frame scheduler and the RMII frame transmitter.
// The scheduler uses the master modport and the environment uses the slave modport.
interface eth_frame_scheduler_if;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        frame_start;
    logic        frame_busy;
    logic        payload_req;
    logic [1:0]  payload_dibit;
    logic        payload_last;

    modport master (
        input  sample_valid,
        input  sample_data,
        input  frame_busy,
        input  payload_req,
        output frame_start,
        output payload_dibit,
        output payload_last
    );

    modport slave (
        output sample_valid,
        output sample_data,
        output frame_busy,
        output payload_req,
        input  frame_start,
        input  payload_dibit,
        input  payload_last
    );
endinterface

// File: rtl/eth_frame_scheduler.sv
// Ping-pong audio sample buffer that feeds RMII frame payloads as show-ahead di-bits and enforces an inter-frame gap.
// Optional frames_sent/drop_count statistics ports exist only when ETH_SCHED_STATS_EN is defined.
module eth_frame_scheduler #(
    parameter int SAMPLES_PER_FRAME = 32,
    parameter int SAMPLE_WIDTH      = 16,
    parameter int MIN_GAP_CYCLES    = 48
) (
    input  logic                 eth_clk,
    input  logic                 eth_rst,
    eth_frame_scheduler_if.master bus,
`ifdef ETH_SCHED_STATS_EN
    output logic [15:0]          frames_sent,
    output logic [15:0]          drop_count,
`endif
    output logic                 overflow
);
    localparam int IDX_W   = $clog2(SAMPLES_PER_FRAME);
    localparam int DIBIT_W = IDX_W + 3;
    localparam int GAP_W   = (MIN_GAP_CYCLES < 2) ? 1 : $clog2(MIN_GAP_CYCLES + 1);
    localparam logic [DIBIT_W-1:0] LAST_DIBIT = DIBIT_W'(SAMPLES_PER_FRAME * 8 - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(SAMPLES_PER_FRAME - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(MIN_GAP_CYCLES);

    typedef enum logic [2:0] {IDLE, START, SEND, DRAIN, GAP} state_t;

    state_t               state_reg;
    logic                 wbank_reg;
    logic                 rbank_reg;
    logic [IDX_W-1:0]     widx_reg;
    logic [DIBIT_W-1:0]   ridx_reg;
    logic [1:0]           full_reg;
    logic [GAP_W-1:0]     gap_reg;
    logic                 frame_start_reg;
    logic                 overflow_reg;
    logic [15:0]          frames_sent_reg;
    logic [15:0]          drop_count_reg;

    logic [SAMPLE_WIDTH-1:0] mem [0:2*SAMPLES_PER_FRAME-1];

    logic                    rel_bank;
    logic                    wr_blocked;
    logic                    wr_accept;
    logic                    wr_drop;
    logic                    wr_complete;
    logic [SAMPLE_WIDTH-1:0] rd_sample;
    logic [7:0]              rd_byte;
    logic [1:0]              dibit_next;
    logic                    last_next;

    // A bank released this cycle is writable again in the same cycle.
    assign rel_bank    = (state_reg == SEND) && bus.payload_req && (ridx_reg == LAST_DIBIT);
    assign wr_blocked  = full_reg[wbank_reg] && !(rel_bank && (rbank_reg == wbank_reg));
    assign wr_accept   = bus.sample_valid && !wr_blocked;
    assign wr_drop     = bus.sample_valid && wr_blocked;
    assign wr_complete = wr_accept && (widx_reg == LAST_IDX);

    always_ff @(posedge eth_clk) begin
        if (wr_accept) begin
            mem[{wbank_reg, widx_reg}] <= bus.sample_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_full
            always_ff @(posedge eth_clk) begin
                if (eth_rst) begin
                    full_reg[gi] <= 1'b0;
                end else if (wr_complete && (wbank_reg == 1'(gi))) begin
                    full_reg[gi] <= 1'b1;
                end else if (rel_bank && (rbank_reg == 1'(gi))) begin
                    full_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            wbank_reg      <= 1'b0;
            widx_reg       <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (wr_accept) begin
                if (widx_reg == LAST_IDX) begin
                    widx_reg  <= '0;
                    wbank_reg <= ~wbank_reg;
                end else begin
                    widx_reg <= widx_reg + 1'b1;
                end
            end
            if (wr_drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != 16'hFFFF) begin
                    drop_count_reg <= drop_count_reg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state_reg       <= IDLE;
            rbank_reg       <= 1'b0;
            ridx_reg        <= '0;
            gap_reg         <= '0;
            frame_start_reg <= 1'b0;
            frames_sent_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (full_reg[rbank_reg] && (gap_reg == '0)) begin
                        state_reg       <= START;
                        frame_start_reg <= 1'b1;
                    end
                end
                START: begin
                    if (bus.frame_busy) begin
                        state_reg       <= SEND;
                        frame_start_reg <= 1'b0;
                        ridx_reg        <= '0;
                    end
                end
                SEND: begin
                    if (bus.payload_req) begin
                        if (ridx_reg == LAST_DIBIT) begin
                            ridx_reg        <= '0;
                            rbank_reg       <= ~rbank_reg;
                            frames_sent_reg <= frames_sent_reg + 16'd1;
                            state_reg       <= DRAIN;
                        end else begin
                            ridx_reg <= ridx_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.frame_busy) begin
                        gap_reg   <= GAP_LOAD;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (gap_reg <= GAP_W'(1)) begin
                        gap_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        gap_reg <= gap_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Asynchronous read keeps the current di-bit visible in the cycle the transmitter samples it.
    // Index layout: sample number, then byte (MS byte first), then di-bit within the byte.
    assign rd_sample = mem[{rbank_reg, ridx_reg[DIBIT_W-1:3]}];
    assign rd_byte   = ridx_reg[2] ? rd_sample[7:0] : rd_sample[15:8];

    always_comb begin
        dibit_next = 2'b00;
        last_next  = 1'b0;
        if (state_reg == SEND) begin
            dibit_next = rd_byte[{ridx_reg[1:0], 1'b0} +: 2];
            last_next  = (ridx_reg == LAST_DIBIT);
        end
    end

    assign bus.frame_start   = frame_start_reg;
    assign bus.payload_dibit = dibit_next;
    assign bus.payload_last  = last_next;
    assign overflow          = overflow_reg;

`ifdef ETH_SCHED_STATS_EN
    assign frames_sent = frames_sent_reg;
    assign drop_count  = drop_count_reg;
`else
    logic unused_stats;
    assign unused_stats = ^{frames_sent_reg, drop_count_reg};
`endif
endmodule

// File: tb/tb_eth_frame_scheduler.sv
// Directed bench for eth_frame_scheduler: single frame, ping-pong streaming, overflow, gap, same-cycle release, reset mid-frame.
// Statistics checks are compiled in only when ETH_SCHED_STATS_EN is defined.
module tb_eth_frame_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow;
`ifdef ETH_SCHED_STATS_EN
    logic [15:0] frames_sent;
    logic [15:0] drop_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int t_fall  = 0;
    int last_pos;
    logic [15:0] smp  [0:127];
    logic [1:0]  obs  [0:255];
    logic [1:0]  ref8 [0:7];

    eth_frame_scheduler_if bus_if ();

    eth_frame_scheduler dut (
        .eth_clk     (clk),
        .eth_rst     (rst),
        .bus         (bus_if),
`ifdef ETH_SCHED_STATS_EN
        .frames_sent (frames_sent),
        .drop_count  (drop_count),
`endif
        .overflow    (overflow)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        bus_if.sample_valid  = 1'b0;
        bus_if.sample_data   = 16'h0000;
        bus_if.frame_busy    = 1'b0;
        bus_if.payload_req   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        bus_if.sample_valid = 1'b1;
        bus_if.sample_data  = d;
        tick();
        bus_if.sample_valid = 1'b0;
    endtask

    function automatic logic [1:0] exp_dibit(input logic [15:0] s, input int k);
        logic [7:0] b;
        b = (((k / 4) % 2) == 0) ? s[15:8] : s[7:0];
        return b[2 * (k % 4) +: 2];
    endfunction

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus_if.frame_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("start_timeout", 32'd0, 32'd1);
    endtask

    // Transmitter model: busy two cycles after frame_start, continuous requests, busy drops one cycle after the last di-bit.
    task automatic tx_frame(input int base, input int abort_at, input bit gap_chk,
                            input bit inject, input logic [15:0] inj_data);
        bit ok;
        int gap;
        wait_start(ok);
        if (!ok) return;
        if (gap_chk) begin
            gap = cyc - t_fall;
            check("gap_min", 32'(gap >= 48), 32'd1);
            check("gap_max", 32'(gap <= 52), 32'd1);
        end
        tick();
        tick();
        bus_if.frame_busy = 1'b1;
        check("start_held", 32'(bus_if.frame_start), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus_if.frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("busy_ack_timeout", 32'd0, 32'd1);
            return;
        end
        last_pos = -1;
        for (int k = 0; k < 256; k++) begin
            if (k == abort_at) return;
            obs[k] = bus_if.payload_dibit;
            check("dibit", 32'(bus_if.payload_dibit), 32'(exp_dibit(smp[base + k / 8], k)));
            check("last", 32'(bus_if.payload_last), 32'(k == 255));
            if (bus_if.payload_last) last_pos = k;
            bus_if.payload_req = 1'b1;
            if (inject && k == 255) begin
                bus_if.sample_valid = 1'b1;
                bus_if.sample_data  = inj_data;
            end
            tick();
            bus_if.payload_req = 1'b0;
            if (inject && k == 255) bus_if.sample_valid = 1'b0;
        end
        check("dibit_idle", 32'(bus_if.payload_dibit), 32'd0);
        check("last_idle", 32'(bus_if.payload_last), 32'd0);
        tick();
        bus_if.frame_busy = 1'b0;
        t_fall = cyc;
    endtask

    initial begin
        ref8[0] = 2'b10; ref8[1] = 2'b00; ref8[2] = 2'b01; ref8[3] = 2'b00;
        ref8[4] = 2'b00; ref8[5] = 2'b01; ref8[6] = 2'b11; ref8[7] = 2'b00;

        do_reset();
        check("rst_frame_start", 32'(bus_if.frame_start), 32'd0);
        check("rst_dibit", 32'(bus_if.payload_dibit), 32'd0);
        check("rst_last", 32'(bus_if.payload_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
`ifdef ETH_SCHED_STATS_EN
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
`endif

        // Single frame with request latency check
        for (int i = 0; i < 32; i++) smp[i] = (i == 0) ? 16'h1234 : 16'(i);
        for (int i = 0; i < 31; i++) push(smp[i]);
        push(smp[31]);
        check("start_early", 32'(bus_if.frame_start), 32'd0);
        tick();
        check("start_latency", 32'(bus_if.frame_start), 32'd1);
        tx_frame(0, -1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) check("first8", 32'(obs[i]), 32'(ref8[i]));
        check("last_pos", 32'(last_pos), 32'd255);
`ifdef ETH_SCHED_STATS_EN
        check("frames_sent_1", 32'(frames_sent), 32'd1);
`endif
        $display("single frame done, vectors=%0d", vec_cnt);

        // Ping-pong streaming, 1 sample per 8 cycles, frames 2 and 3 are gap-limited
        do_reset();
        for (int i = 0; i < 96; i++) smp[i] = 16'(i * 16'h0123 + 16'h0F0F);
        fork
            begin
                for (int i = 0; i < 96; i++) begin
                    push(smp[i]);
                    repeat (7) tick();
                end
            end
            begin
                tx_frame(0, -1, 1'b0, 1'b0, 16'h0000);
                tx_frame(32, -1, 1'b1, 1'b0, 16'h0000);
                tx_frame(64, -1, 1'b1, 1'b0, 16'h0000);
            end
        join
        check("pp_overflow", 32'(overflow), 32'd0);
`ifdef ETH_SCHED_STATS_EN
        check("pp_frames_sent", 32'(frames_sent), 32'd3);
`endif
        $display("ping-pong done, vectors=%0d", vec_cnt);

        // Overflow: transmitter never answers, sample 65 is dropped
        do_reset();
        for (int i = 0; i < 64; i++) push(16'(i));
        check("ovf_pre", 32'(overflow), 32'd0);
        push(16'hDEAD);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_start_held", 32'(bus_if.frame_start), 32'd1);
`ifdef ETH_SCHED_STATS_EN
        check("ovf_drop_count", 32'(drop_count), 32'd1);
`endif
        $display("overflow done, vectors=%0d", vec_cnt);

        // Same-cycle release and write into the released bank
        do_reset();
        for (int i = 0; i < 96; i++) smp[i] = 16'(i * 16'h0101 + 16'h0007);
        smp[64] = 16'hBEEF;
        for (int i = 0; i < 64; i++) push(smp[i]);
        check("sc_pre_overflow", 32'(overflow), 32'd0);
        tx_frame(0, -1, 1'b0, 1'b1, 16'hBEEF);
        check("sc_overflow", 32'(overflow), 32'd0);
        tx_frame(32, -1, 1'b1, 1'b0, 16'h0000);
        for (int i = 65; i < 96; i++) push(smp[i]);
        tx_frame(64, -1, 1'b1, 1'b0, 16'h0000);
        check("sc_final_overflow", 32'(overflow), 32'd0);
        $display("same-cycle release done, vectors=%0d", vec_cnt);

        // Reset after 100 di-bits abandons the frame
        do_reset();
        for (int i = 0; i < 32; i++) smp[i] = 16'(16'hFFFF - i);
        for (int i = 0; i < 32; i++) push(smp[i]);
        tx_frame(0, 100, 1'b0, 1'b0, 16'h0000);
        rst = 1'b1;
        tick();
        check("mid_rst_start", 32'(bus_if.frame_start), 32'd0);
        check("mid_rst_dibit", 32'(bus_if.payload_dibit), 32'd0);
        check("mid_rst_last", 32'(bus_if.payload_last), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        bus_if.frame_busy  = 1'b0;
        bus_if.payload_req = 1'b1;
        tick();
        check("post_rst_dibit", 32'(bus_if.payload_dibit), 32'd0);
        check("post_rst_start", 32'(bus_if.frame_start), 32'd0);
        bus_if.payload_req = 1'b0;
        for (int i = 0; i < 32; i++) push(smp[i]);
        check("post_rst_start_early", 32'(bus_if.frame_start), 32'd0);
        tick();
        check("post_rst_start_latency", 32'(bus_if.frame_start), 32'd1);
        $display("reset mid-frame done, vectors=%0d", vec_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
